// File: rtl/pci_bridge_wb_arb_pkg.sv
// rtl/pci_bridge_wb_arb_pkg.sv - shared types and widths for the WISHBONE slave-port arbiter
package pci_bridge_wb_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int PTR_W       = $clog2(MAX_MASTERS);

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pci_bridge_rr_picker.sv
// rtl/pci_bridge_rr_picker.sv - combinational round-robin winner select
module pci_bridge_rr_picker
    import pci_bridge_wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 4
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [N_MASTERS-1:0] winner,
    output logic                 valid
);

    int idx;

    // Scan starting one past the last owner, wrapping, and take the first requester.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            idx = (int'(rr_ptr) + off) % N_MASTERS;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bridge_wb_arbiter.sv
// rtl/pci_bridge_wb_arbiter.sv - round-robin sharing of the bridge WISHBONE slave port with watchdog
module pci_bridge_wb_arbiter
    import pci_bridge_wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MASTERS-1:0]       m_cyc,
    input  logic [N_MASTERS-1:0]       m_stb,
    input  logic [N_MASTERS-1:0]       m_we,
    input  logic [N_MASTERS-1:0]       m_cab,
    input  logic [ADR_W*N_MASTERS-1:0] m_adr,
    input  logic [DAT_W*N_MASTERS-1:0] m_dat,
    input  logic [SEL_W*N_MASTERS-1:0] m_sel,
    input  logic [CTI_W*N_MASTERS-1:0] m_cti,
    input  logic [BTE_W*N_MASTERS-1:0] m_bte,
    output logic [N_MASTERS-1:0]       m_ack,
    output logic [N_MASTERS-1:0]       m_rty,
    output logic [N_MASTERS-1:0]       m_err,
    output logic [DAT_W-1:0]           m_dat_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic                       wb_cab_o,
    output logic [ADR_W-1:0]           wb_adr_o,
    output logic [DAT_W-1:0]           wb_dat_o,
    output logic [SEL_W-1:0]           wb_sel_o,
    output logic [CTI_W-1:0]           wb_cti_o,
    output logic [BTE_W-1:0]           wb_bte_o,
    input  logic [DAT_W-1:0]           wb_dat_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_rty_i,
    input  logic                       wb_err_i,
    output logic [N_MASTERS-1:0]       gnt,
    output logic                       timeout_evt
);

    localparam int              CNT_W    = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     wd_cnt;

    logic [N_MASTERS-1:0] pick;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;

    logic                 own_cyc, own_stb, own_we, own_cab;
    logic [ADR_W-1:0]     own_adr;
    logic [DAT_W-1:0]     own_dat;
    logic [SEL_W-1:0]     own_sel;
    logic [CTI_W-1:0]     own_cti;
    logic [BTE_W-1:0]     own_bte;

    logic                 busy, term, fire;

    pci_bridge_rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
        .req    (m_cyc),
        .rr_ptr (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    // Encode the one-hot winner so rr_ptr can remember the last owner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // Select the owning master's bus fields; gnt is zero outside an ownership so everything reads 0.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_cab = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_cti = '0;
        own_bte = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                own_cyc = m_cyc[i];
                own_stb = m_stb[i];
                own_we  = m_we[i];
                own_cab = m_cab[i];
                own_adr = m_adr[i*ADR_W +: ADR_W];
                own_dat = m_dat[i*DAT_W +: DAT_W];
                own_sel = m_sel[i*SEL_W +: SEL_W];
                own_cti = m_cti[i*CTI_W +: CTI_W];
                own_bte = m_bte[i*BTE_W +: BTE_W];
            end
        end
    end

    assign busy = (state == ST_BUSY);
    assign term = wb_ack_i | wb_rty_i | wb_err_i;
    // A real termination in the last watchdog cycle beats the abort.
    assign fire = busy && own_cyc && own_stb && !term && (wd_cnt == CNT_LAST);

    assign wb_cyc_o = busy & own_cyc & ~fire;
    assign wb_stb_o = busy & own_cyc & own_stb & ~fire;
    assign wb_we_o  = busy & own_we;
    assign wb_cab_o = busy & own_cab;
    assign wb_adr_o = busy ? own_adr : '0;
    assign wb_dat_o = busy ? own_dat : '0;
    assign wb_sel_o = busy ? own_sel : '0;
    assign wb_cti_o = busy ? own_cti : '0;
    assign wb_bte_o = busy ? own_bte : '0;

    // Terminations only count while a cycle is actually on the bus, and only reach the owner.
    assign m_ack   = gnt & {N_MASTERS{wb_ack_i & wb_cyc_o}};
    assign m_rty   = gnt & {N_MASTERS{wb_rty_i & wb_cyc_o}};
    assign m_err   = gnt & {N_MASTERS{(wb_err_i & wb_cyc_o) | fire}};
    assign m_dat_o = wb_dat_i;
    assign timeout_evt = fire;

    // Watchdog: count stalled strobe cycles, restart on any termination or strobe drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (!wb_stb_o || term) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Ownership FSM: grant on request, hold for the whole CYC, park in ABORT after a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            rr_ptr <= PTR_W'(N_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state  <= ST_BUSY;
                        gnt    <= pick;
                        rr_ptr <= pick_idx;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end else if (fire) begin
                        state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_bridge_wb_arbiter.sv
// tb/tb_pci_bridge_wb_arbiter.sv - scoreboard bench for the WISHBONE slave-port arbiter
module tb_pci_bridge_wb_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  m_cyc, m_stb, m_we, m_cab;
    logic [32*N-1:0] m_adr, m_dat;
    logic [4*N-1:0]  m_sel;
    logic [3*N-1:0]  m_cti;
    logic [2*N-1:0]  m_bte;
    logic [N-1:0]  m_ack, m_rty, m_err;
    logic [31:0]   m_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_cab_o;
    logic [31:0]   wb_adr_o, wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i, wb_rty_i, wb_err_i;
    logic [N-1:0]  gnt;
    logic          timeout_evt;

    pci_bridge_wb_arbiter #(.N_MASTERS(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_cab(m_cab),
        .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_rty(m_rty), .m_err(m_err), .m_dat_o(m_dat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_cab_o(wb_cab_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i), .wb_err_i(wb_err_i),
        .gnt(gnt), .timeout_evt(timeout_evt)
    );

    typedef struct {
        logic [N-1:0] ack;
        logic [N-1:0] rty;
        logic [N-1:0] err;
        logic         tevt;
        logic         chk_dat;
        logic [31:0]  dat;
    } rsp_t;

    logic [N-1:0] gnt_q[$];
    rsp_t         rsp_q[$];
    logic [N-1:0] last_gnt;
    int           n_cmp;
    int           n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input logic [N-1:0] g);
        gnt_q.push_back(g);
    endtask

    task automatic push_rsp(input logic [N-1:0] ack, input logic [N-1:0] rty, input logic [N-1:0] err,
                            input logic tevt, input logic chk_dat, input logic [31:0] dat);
        rsp_t e;
        e.ack = ack; e.rty = rty; e.err = err; e.tevt = tevt; e.chk_dat = chk_dat; e.dat = dat;
        rsp_q.push_back(e);
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_adr[i*32 +: 32] = adr;
        m_dat[i*32 +: 32] = dat;
        m_cti[i*3 +: 3]   = cti;
        m_sel[i*4 +: 4]   = 4'hF;
    endtask

    // Monitor: every grant change and every termination/abort pulse is matched against the queues.
    always @(negedge clk) begin
        if (gnt !== last_gnt) begin
            n_cmp++;
            if (gnt_q.size() == 0) begin
                n_fail++;
                $display("FAIL gnt_unexpected: got %b, required no change from %b", gnt, last_gnt);
            end else begin
                logic [N-1:0] eg;
                eg = gnt_q.pop_front();
                if (gnt !== eg) begin
                    n_fail++;
                    $display("FAIL gnt_seq: got %b, required %b", gnt, eg);
                end
            end
            last_gnt = gnt;
        end
        if ((m_ack | m_rty | m_err) != '0 || timeout_evt) begin
            n_cmp++;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got ack=%b rty=%b err=%b tevt=%b, required none",
                         m_ack, m_rty, m_err, timeout_evt);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                if (m_ack !== e.ack || m_rty !== e.rty || m_err !== e.err || timeout_evt !== e.tevt ||
                    (e.chk_dat && m_dat_o !== e.dat)) begin
                    n_fail++;
                    $display("FAIL rsp: got ack=%b rty=%b err=%b tevt=%b dat=%h, required ack=%b rty=%b err=%b tevt=%b dat=%h",
                             m_ack, m_rty, m_err, timeout_evt, m_dat_o, e.ack, e.rty, e.err, e.tevt, e.dat);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        last_gnt = '0;
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_cab = '0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rst_stb", 32'(wb_stb_o), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_term", 32'({m_ack, m_rty, m_err}), 32'h0);
        chk("rst_tevt", 32'(timeout_evt), 32'h0);
        chk("rst_dat_follow", m_dat_o, 32'h1234_5678);
        tick;
        rst_n = 1'b1;

        // Masters 0 and 2 request together; 0 wins first, then 2 after one idle cycle
        tick;
        set_m(0, 1, 1, 1, 32'h1000_0000, 32'hA5A5_0000, 3'b000);
        set_m(2, 1, 1, 0, 32'h2000_0040, 32'h0, 3'b000);
        push_gnt(4'b0001);
        tick;
        wb_ack_i = 1'b1;
        push_rsp(4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_cyc", 32'(wb_cyc_o), 32'h1);
        chk("t1_adr", wb_adr_o, 32'h1000_0000);
        chk("t1_wdat", wb_dat_o, 32'hA5A5_0000);
        chk("t1_we", 32'(wb_we_o), 32'h1);
        tick;
        wb_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        push_gnt(4'b0100);
        @(negedge clk);
        chk("t1_release_cyc", 32'(wb_cyc_o), 32'h0);
        tick;
        @(negedge clk);
        chk("t1_idle_cyc", 32'(wb_cyc_o), 32'h0);

        // Master 2 read routing, then RTY keeps the grant
        tick;
        wb_dat_i = 32'hDEAD_BEEF;
        wb_ack_i = 1'b1;
        push_rsp(4'b0100, 4'b0, 4'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_adr", wb_adr_o, 32'h2000_0040);
        chk("t2_we", 32'(wb_we_o), 32'h0);
        tick;
        wb_ack_i = 1'b0;
        wb_rty_i = 1'b1;
        push_rsp(4'b0, 4'b0100, 4'b0, 1'b0, 1'b0, 32'h0);
        tick;
        wb_rty_i = 1'b0;
        @(negedge clk);
        chk("t2_rty_keep_gnt", 32'(gnt), 32'h4);
        chk("t2_rty_keep_cyc", 32'(wb_cyc_o), 32'h1);
        tick;
        wb_ack_i = 1'b1;
        push_rsp(4'b0100, 4'b0, 4'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick;
        wb_ack_i = 1'b0;
        set_m(2, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        tick;
        tick;

        // Fairness: all four request; rotation 0,1,2,3,0 with one idle cycle between owners
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < N; i++) set_m(i, 1, 1, 0, 32'h3000_0000 + 32'(i * 16), 32'h0, 3'b000);
        for (int r = 0; r < 5; r++) begin
            int o;
            o = r % N;
            push_gnt(4'(1 << o));
            push_gnt(4'b0000);
            tick;
            wb_ack_i = 1'b1;
            push_rsp(4'(1 << o), 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
            tick;
            wb_ack_i = 1'b0;
            m_cyc[o] = 1'b0;
            m_stb[o] = 1'b0;
            tick;
            if (r < 4) begin
                m_cyc[o] = 1'b1;
                m_stb[o] = 1'b1;
            end else begin
                m_cyc = '0;
                m_stb = '0;
            end
        end

        // Burst atomicity: master 1 runs 8 beats while master 3 waits
        tick;
        set_m(1, 1, 1, 0, 32'h4000_0000, 32'h0, 3'b010);
        set_m(3, 1, 1, 1, 32'h5000_0000, 32'h0BAD_F00D, 3'b000);
        push_gnt(4'b0010);
        tick;
        for (int b = 0; b < 8; b++) begin
            m_adr[63:32] = 32'h4000_0000 + 32'(b * 4);
            m_cti[5:3]   = (b == 7) ? 3'b111 : 3'b010;
            wb_dat_i     = 32'hB000_0000 + 32'(b);
            wb_ack_i     = 1'b1;
            push_rsp(4'b0010, 4'b0, 4'b0, 1'b0, 1'b1, 32'hB000_0000 + 32'(b));
            @(negedge clk);
            chk("t3_gnt_hold", 32'(gnt), 32'h2);
            chk("t3_adr", wb_adr_o, 32'h4000_0000 + 32'(b * 4));
            chk("t3_cti", 32'(wb_cti_o), (b == 7) ? 32'h7 : 32'h2);
            tick;
        end
        wb_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        push_gnt(4'b1000);
        @(negedge clk);
        chk("t3_gnt_after_burst", 32'(gnt), 32'h2);
        chk("t3_release_cyc", 32'(wb_cyc_o), 32'h0);
        tick;
        tick;

        // Timeout: master 3 owns the bus, the bridge never answers
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("t4_wait_stb", 32'(wb_stb_o), 32'h1);
            tick;
        end
        push_rsp(4'b0, 4'b0, 4'b1000, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_fire_cyc", 32'(wb_cyc_o), 32'h0);
        chk("t4_fire_stb", 32'(wb_stb_o), 32'h0);
        tick;
        wb_ack_i = 1'b1;
        @(negedge clk);
        chk("t4_abort_cyc", 32'(wb_cyc_o), 32'h0);
        chk("t4_abort_gnt", 32'(gnt), 32'h8);
        tick;
        wb_ack_i = 1'b0;
        set_m(3, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        tick;

        // ACK in the firing cycle wins over the abort
        tick;
        set_m(0, 1, 1, 0, 32'h6000_0000, 32'h0, 3'b000);
        push_gnt(4'b0001);
        tick;
        repeat (15) tick;
        wb_ack_i = 1'b1;
        push_rsp(4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
        tick;
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("t5_gnt_kept", 32'(gnt), 32'h1);
        chk("t5_cyc_kept", 32'(wb_cyc_o), 32'h1);
        chk("t5_no_tevt", 32'(timeout_evt), 32'h0);
        tick;
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        tick;

        // Asynchronous reset in the middle of a burst
        tick;
        set_m(1, 1, 1, 1, 32'h7000_0000, 32'h7777_0000, 3'b010);
        push_gnt(4'b0010);
        tick;
        wb_ack_i = 1'b1;
        push_rsp(4'b0010, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
        tick;
        push_rsp(4'b0010, 4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
        tick;
        push_gnt(4'b0000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("t6_rst_stb", 32'(wb_stb_o), 32'h0);
        chk("t6_rst_adr", wb_adr_o, 32'h0);
        chk("t6_rst_ack", 32'(m_ack), 32'h0);
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        wb_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        tick;
        rst_n = 1'b1;
        tick;
        @(negedge clk);
        chk("t6_gnt_after_rst", 32'(gnt), 32'h0);
        tick;
        set_m(1, 1, 1, 0, 32'h7100_0000, 32'h0, 3'b000);
        set_m(2, 1, 1, 0, 32'h7200_0000, 32'h0, 3'b000);
        push_gnt(4'b0010);
        tick;
        tick;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        set_m(2, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        push_gnt(4'b0000);
        repeat (3) tick;

        chk("gnt_queue_empty", 32'(gnt_q.size()), 32'h0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
